reg_scoreboard: RTL and testbench

- Per-register pending-write tracker for the 5-stage RISC-V pipeline.
- Records every destination register issued from ID and counts down the cycles until its result can be forwarded.
- Answers ID-stage source-register queries and drives the pipeline hold and bubble controls (PCWrite, IF_ID_Write, ID_EX_Bubble).
- Generalises single-cycle load-use detection to multi-cycle producers and memory wait states; sits beside the ID stage.

---
 rtl/reg_scoreboard.sv | 81 ++++++++
 tb/tb_reg_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard beside the ID stage. It counts down each
// in-flight destination until forwardable and drives the hold/bubble controls.
module reg_scoreboard #(
  parameter int MAX_LAT = 3,
  parameter int NREG    = 32,
  parameter int SCW     = 16,
  localparam int CW     = $clog2(MAX_LAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_issue,
  input  logic [4:0]     id_rd,
  input  logic [CW-1:0]  id_lat,
  input  logic [4:0]     id_AddrA,
  input  logic [4:0]     id_AddrB,
  input  logic           id_UseA,
  input  logic           id_UseB,
  input  logic           mem_stall,
  input  logic           ex_flush,
  output logic           PCWrite,
  output logic           IF_ID_Write,
  output logic           ID_EX_Bubble,
  output logic           hz_stall,
  output logic [SCW-1:0] stall_cnt
);

  // Each entry holds the number of remaining cycles in which a reader must stall.
  logic [CW-1:0] cnt [NREG];
  logic [4:0]    last_rd;
  logic          last_valid;
  logic          hz_a;
  logic          hz_b;
  logic          accept;

  // Latency L gives L-1 stall cycles, so the stored count is min(L, MAX_LAT) - 1.
  function automatic logic [CW-1:0] lat_to_cnt(input logic [CW-1:0] lat);
    logic [CW-1:0] l;
    l = (lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : lat;
    return (l == '0) ? '0 : l - CW'(1);
  endfunction

  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
    return (&v) ? v : v + SCW'(1);
  endfunction

  always_comb begin
    hz_a         = id_UseA && (id_AddrA != 5'd0) && (cnt[id_AddrA] != '0);
    hz_b         = id_UseB && (id_AddrB != 5'd0) && (cnt[id_AddrB] != '0);
    hz_stall     = (hz_a || hz_b) && !ex_flush;
    PCWrite      = !(hz_stall || mem_stall);
    IF_ID_Write  = !(hz_stall || mem_stall);
    ID_EX_Bubble = hz_stall && !mem_stall;
    accept       = id_issue && !hz_stall && !mem_stall && !ex_flush && (id_rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      last_rd    <= 5'd0;
      last_valid <= 1'b0;
    end else begin
      if (!mem_stall) begin
        for (int i = 1; i < NREG; i++)
          if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
        last_valid <= accept;
        if (accept) last_rd <= id_rd;
      end
      // A squashed EX producer is cancelled even while memory holds the pipe.
      if (ex_flush && last_valid) cnt[last_rd] <= '0;
      if (accept && (id_lat != '0)) cnt[id_rd] <= lat_to_cnt(id_lat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hz_stall && !mem_stall)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic checked against
// a model that tracks, per register, the unfrozen-cycle index at which it becomes free.
module tb_reg_scoreboard;
  localparam int MAX_LAT = 3;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_issue, id_UseA, id_UseB, mem_stall, ex_flush;
  logic [4:0]  id_rd, id_AddrA, id_AddrB;
  logic [CW-1:0] id_lat;
  logic        PCWrite, IF_ID_Write, ID_EX_Bubble, hz_stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  int ready_at [32];
  int progress = 0;
  int m_last_rd = 0;
  bit m_last_valid = 0;
  int m_stalls = 0;

  reg_scoreboard #(.MAX_LAT(MAX_LAT), .NREG(32), .SCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_issue(id_issue), .id_rd(id_rd), .id_lat(id_lat),
    .id_AddrA(id_AddrA), .id_AddrB(id_AddrB), .id_UseA(id_UseA), .id_UseB(id_UseB),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble), .hz_stall(hz_stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && (progress < ready_at[r]);
  endfunction

  function automatic bit m_hz();
    return !ex_flush && ((id_UseA && m_busy(id_AddrA)) || (id_UseB && m_busy(id_AddrB)));
  endfunction

  function automatic logic [19:0] exp_vec();
    bit h;
    h = m_hz();
    return {h, !(h || mem_stall), !(h || mem_stall), h && !mem_stall, 16'(m_stalls)};
  endfunction

  function automatic logic [19:0] act_vec();
    return {hz_stall, PCWrite, IF_ID_Write, ID_EX_Bubble, stall_cnt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    m_last_valid = 0;
    m_last_rd = 0;
    m_stalls = 0;
  endtask

  task automatic drive(input bit iss, input int rd, input int lat, input int a, input bit ua,
                       input int b, input bit ub, input bit ms, input bit fl);
    id_issue = iss; id_rd = 5'(rd); id_lat = CW'(lat);
    id_AddrA = 5'(a); id_UseA = ua; id_AddrB = 5'(b); id_UseB = ub;
    mem_stall = ms; ex_flush = fl;
    #1;
  endtask

  task automatic tick();
    bit h, acc;
    int l;
    h = m_hz();
    acc = id_issue && !h && !mem_stall && !ex_flush && (id_rd != 5'd0);
    @(posedge clk);
    if (rst_n) begin
      if (ex_flush && m_last_valid) ready_at[m_last_rd] = 0;
      if (!mem_stall) begin
        l = (int'(id_lat) > MAX_LAT) ? MAX_LAT : int'(id_lat);
        if (acc && l != 0) ready_at[id_rd] = progress + l;
        m_last_valid = acc;
        if (acc) m_last_rd = int'(id_rd);
        if (h && m_stalls != 16'hFFFF) m_stalls++;
        progress++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hz_stall, PCWrite, IF_ID_Write, ID_EX_Bubble} !== 4'b0110) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0110", {hz_stall, PCWrite, IF_ID_Write, ID_EX_Bubble});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    int stalls = 0;
    bit was;
    drive(1, 5, 2, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 10, 1, 5, 1, 0, 0, 0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL load_use cyc%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      was = hz_stall;
      if (was) stalls++;
      tick();
      if (!was) break;
    end
    checks++;
    if (stalls != 1) begin failures++; $display("FAIL load_use_stalls got=%0d want=1", stalls); end
    checks++;
    if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_lat3();
    int stalls = 0;
    bit was;
    drive(1, 7, 3, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 7, 1, 0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL lat3 cyc%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      was = hz_stall;
      if (was) stalls++;
      tick();
      if (!was) break;
    end
    checks++;
    if (stalls != 2) begin failures++; $display("FAIL lat3_stalls got=%0d want=2", stalls); end
    drive(1, 11, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 8, 1, 0, 0);
    checks++;
    if (hz_stall !== 1'b0) begin failures++; $display("FAIL lat3_indep got=%b want=0", hz_stall); end
    tick();
  endtask

  task automatic test_x0_useb();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0);
    checks++;
    if (hz_stall !== 1'b0) begin failures++; $display("FAIL x0_src got=%b want=0", hz_stall); end
    tick();
    drive(1, 4, 2, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4, 0, 0, 0);
    checks++;
    if (hz_stall !== 1'b0) begin failures++; $display("FAIL useb_gate got=%b want=0", hz_stall); end
    tick();
  endtask

  task automatic test_mem_stall();
    int stalls = 0;
    bit was;
    drive(1, 9, 3, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 9, 1, 0, 0, 1, 0);
      checks++;
      if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b000 || act_vec() !== exp_vec()) begin
        failures++; $display("FAIL mem_freeze cyc%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 9, 1, 0, 0, 0, 0);
      was = hz_stall;
      if (was) stalls++;
      tick();
      if (!was) break;
    end
    checks++;
    if (stalls != 2) begin failures++; $display("FAIL mem_release_stalls got=%0d want=2", stalls); end
  endtask

  task automatic test_flush();
    drive(1, 6, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 12, 3, 6, 1, 0, 0, 0, 1);
    checks++;
    if (hz_stall !== 1'b0) begin failures++; $display("FAIL flush_hz got=%b want=0", hz_stall); end
    tick();
    drive(0, 0, 0, 6, 1, 12, 1, 0, 0);
    checks++;
    if (hz_stall !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b want=0", hz_stall); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, 3, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    checks++;
    if (hz_stall !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b want=1", hz_stall); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({hz_stall, PCWrite, IF_ID_Write, ID_EX_Bubble} !== 4'b0110 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL areset_now got=%b/%0d want=0110/0",
               {hz_stall, PCWrite, IF_ID_Write, ID_EX_Bubble}, stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    checks++;
    if (hz_stall !== 1'b0 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL areset_after got=%b/%0d want=0/0", hz_stall, stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++; $display("FAIL random cyc%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lat3();
    test_x0_useb();
    test_mem_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
